// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_ctrl_pkg
//  Purpose  : Shared control definitions for the 5-stage core front end:
//             major opcodes that cause redirects and the hazard FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package core_ctrl_pkg;

   // Major opcodes that can redirect the PC from EX
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // Hazard unit state: IDLE, or EX occupied by a multi-cycle multiply
   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } hz_state_e;

endpackage : core_ctrl_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Event counter that sticks at all-ones instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         inc,
   output logic [W-1:0] value
);

   logic [W-1:0] value_q;

   // Count qualifying events, holding once every bit is set
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         value_q <= '0;
      end else if (inc && !(&value_q)) begin
         value_q <= value_q + 1'b1;
      end
   end

   assign value = value_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Hazard / pipeline control for the 5-stage core: load-use
//             stalls, branch/jump redirect with optional two-deep squash,
//             multi-cycle multiply occupancy and saturating perf counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int MUL_LATENCY = 4,
   parameter int FLUSH_DEPTH = 1,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  mem_read_id_ex,
   input  logic [REG_ADDR_W-1:0] rd_id_ex,
   input  logic [REG_ADDR_W-1:0] rs1_if_id,
   input  logic [REG_ADDR_W-1:0] rs2_if_id,
   input  logic                  rs2_used_if_id,
   input  logic                  branch_taken_ex,
   input  logic                  jump_ex,
   input  logic                  mul_start_ex,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  if_id_flush,
   output logic                  id_ex_bubble,
   output logic                  ex_hold,
   output logic                  redirect,
   output logic                  mul_done,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   // A latency of 1 completes in a single EX cycle and never stalls
   localparam bit         MUL_STALLS = (MUL_LATENCY > 1);
   // Remaining stall cycles after the start cycle
   localparam logic [3:0] MUL_LOAD   = 4'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);
   localparam bit         SQUASH2    = (FLUSH_DEPTH == 2);

   hz_state_e  state_q, state_d;
   logic [3:0] mul_cnt_q, mul_cnt_d;
   logic       mul_done_q, mul_done_d;
   logic       squash_q, squash_d;

   logic mul_stall;
   logic redirect_req;
   logic load_use;

   assign mul_stall    = (state_q == MUL_BUSY) || (mul_start_ex && MUL_STALLS);
   assign redirect_req = branch_taken_ex || jump_ex;
   // x0 is hardwired to zero, so a load targeting it never creates a dependency
   assign load_use     = mem_read_id_ex && (rd_id_ex != '0) &&
                         ((rd_id_ex == rs1_if_id) ||
                          (rs2_used_if_id && (rd_id_ex == rs2_if_id)));

   // State, multiply countdown, done pulse and pending squash registers
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= IDLE;
         mul_cnt_q  <= '0;
         mul_done_q <= 1'b0;
         squash_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         mul_cnt_q  <= mul_cnt_d;
         mul_done_q <= mul_done_d;
         squash_q   <= squash_d;
      end
   end

   // Multiply occupancy: start cycle plus MUL_LOAD busy cycles, done on release
   always_comb begin
      state_d    = state_q;
      mul_cnt_d  = mul_cnt_q;
      mul_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (mul_start_ex && MUL_STALLS) begin
               mul_cnt_d = MUL_LOAD;
               if (MUL_LOAD != 4'd0) begin
                  state_d = MUL_BUSY;
               end else begin
                  mul_done_d = 1'b1;
               end
            end
         end
         MUL_BUSY: begin
            mul_cnt_d = mul_cnt_q - 4'd1;
            if (mul_cnt_q == 4'd1) begin
               state_d    = IDLE;
               mul_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pipeline controls by priority: multiply stall > redirect > load-use
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_hold      = 1'b0;
      redirect     = 1'b0;
      squash_d     = squash_q;
      if (mul_stall) begin
         // Freeze everything; a pending squash waits for the release cycle
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         ex_hold     = 1'b1;
      end else begin
         if (redirect_req) begin
            redirect     = 1'b1;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
         end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
         end
         if (squash_q) begin
            if_id_flush = 1'b1;
         end
         squash_d = redirect_req && SQUASH2;
      end
   end

   assign mul_done = mul_done_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk    (clk),
      .arst_n (arst_n),
      .inc    (!pc_write),
      .value  (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk    (clk),
      .arst_n (arst_n),
      .inc    (redirect),
      .value  (flush_cnt)
   );

endmodule : pipeline_hazard_ctrl
`default_nettype wire
